fixed_point_macc_stream: RTL and testbench

Streaming signed fixed-point multiply-accumulate with valid/ready handshakes on both sides and vector framing via a last flag. Each framed vector of (A,B) pairs is reduced to one dot-product result. The result is then rounded, right-shifted to the output Q-format and sized to the output width. It sits between sample sources and downstream filter/FFT stages and replaces the free-running MACC wherever flow control, guard bits or output scaling are needed.

---
 rtl/fixed_point_macc_stream_if.sv | 29 ++
 rtl/fixed_point_macc_stream.sv | 68 ++++++
 tb/tb_fixed_point_macc_stream.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_macc_stream_if.sv
// fixed_point_macc_stream_if: valid/ready stream bundle for the dot-product MACC
// Input side: i_VALID, o_READY, i_LAST, i_A, i_B. Output side: o_VALID, i_READY,
// o_RESULT and, with FIXED_POINT_MACC_STREAM_SAT_EN defined, o_SAT.
// The slave modport is the MACC; the master modport is the source/sink around it.
interface fixed_point_macc_stream_if #(
  parameter int p_INPUT_WIDTH = 8,
  parameter int p_OUT_WIDTH = 16
);
  logic i_VALID, o_READY, i_LAST, o_VALID, i_READY;
  logic signed [p_INPUT_WIDTH-1:0] i_A, i_B;
  logic signed [p_OUT_WIDTH-1:0] o_RESULT;
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
  logic o_SAT;
`endif
  modport slave (
    input i_VALID, i_LAST, i_A, i_B, i_READY,
    output o_READY, o_VALID, o_RESULT
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
    , output o_SAT
`endif
  );
  modport master (
    output i_VALID, i_LAST, i_A, i_B, i_READY,
    input o_READY, o_VALID, o_RESULT
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
    , input o_SAT
`endif
  );
endinterface

// File: rtl/fixed_point_macc_stream.sv
// fixed_point_macc_stream: framed signed dot product with rounding, shift and output sizing
// Ports: i_CLK, i_RESET (sync, active-high), s = stream interface (slave modport).
// FIXED_POINT_MACC_STREAM_SAT_EN: clamp to p_OUT_WIDTH and report o_SAT; otherwise wrap.
module fixed_point_macc_stream #(
  parameter int p_INPUT_WIDTH = 8,
  parameter int p_GUARD_BITS = 8,
  parameter int p_OUT_WIDTH = 16,
  parameter int p_FRAC_SHIFT = 4
) (
  input logic i_CLK,
  input logic i_RESET,
  fixed_point_macc_stream_if.slave s
);
  localparam int W_P = 2 * p_INPUT_WIDTH;
  localparam int W_ACC = W_P + p_GUARD_BITS;
  // Half an output LSB; collapses to zero when there is no shift.
  localparam logic [W_ACC:0] RND = ((W_ACC+1)'(1) << p_FRAC_SHIFT) >> 1;
  logic stall, in_xfer, p_valid, p_last, out_valid;
  logic signed [W_P-1:0] prod;
  logic signed [W_ACC-1:0] acc, sum;
  logic signed [W_ACC:0] r;
  logic signed [p_OUT_WIDTH-1:0] res, out_result;
  assign stall = out_valid & ~s.i_READY;
  assign in_xfer = s.i_VALID & ~stall;
  assign s.o_READY = ~stall;
  assign s.o_VALID = out_valid;
  assign s.o_RESULT = out_result;
  assign sum = acc + W_ACC'(prod);
  // One extra bit so the rounding addend can never overflow.
  assign r = ((W_ACC+1)'(sum) + $signed(RND)) >>> p_FRAC_SHIFT;
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
  localparam logic signed [W_ACC:0] MAXV = (W_ACC+1)'({(p_OUT_WIDTH-1){1'b1}});
  localparam logic signed [W_ACC:0] MINV = ~MAXV;
  logic hi, lo, out_sat;
  assign hi = r > MAXV;
  assign lo = r < MINV;
  assign res = hi ? MAXV[p_OUT_WIDTH-1:0] : lo ? MINV[p_OUT_WIDTH-1:0] : r[p_OUT_WIDTH-1:0];
  assign s.o_SAT = out_sat;
`else
  assign res = p_OUT_WIDTH'(r);
`endif
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      p_valid <= 1'b0;
      p_last <= 1'b0;
      prod <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
      out_sat <= 1'b0;
`endif
    end else if (!stall) begin
      p_valid <= in_xfer;
      p_last <= in_xfer & s.i_LAST;
      if (in_xfer) prod <= s.i_A * s.i_B;
      // Not stalled means the held result (if any) is being taken this cycle.
      out_valid <= p_valid & p_last;
      if (p_valid) acc <= p_last ? '0 : sum;
      if (p_valid & p_last) begin
        out_result <= res;
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
        out_sat <= hi | lo;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_macc_stream.sv
// tb_fixed_point_macc_stream: directed and randomized checks of the streaming MACC
module tb_fixed_point_macc_stream;
  typedef logic signed [63:0] v64;
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  longint msum = 0;
  longint q[$];
  bit was_stall = 0;
  v64 prev_res = 0;
  always #5 clk = ~clk;
  fixed_point_macc_stream_if #(.p_INPUT_WIDTH(8), .p_OUT_WIDTH(16)) f0 ();
  fixed_point_macc_stream_if #(.p_INPUT_WIDTH(8), .p_OUT_WIDTH(8)) f1 ();
  fixed_point_macc_stream_if #(.p_INPUT_WIDTH(8), .p_OUT_WIDTH(24)) f2 ();
  fixed_point_macc_stream d0 (.i_CLK(clk), .i_RESET(rst), .s(f0));
  fixed_point_macc_stream #(.p_OUT_WIDTH(8), .p_FRAC_SHIFT(0)) d1 (.i_CLK(clk), .i_RESET(rst), .s(f1));
  fixed_point_macc_stream #(.p_OUT_WIDTH(24), .p_FRAC_SHIFT(0)) d2 (.i_CLK(clk), .i_RESET(rst), .s(f2));
  function automatic longint model(longint sm, int f, int ow);
    longint r = sm;
    longint lim = 64'sd1 <<< (ow - 1);
    if (f > 0) r = (sm + (64'sd1 <<< (f - 1))) >>> f;
    if (SAT) r = r >= lim ? lim - 1 : r < -lim ? -lim : r;
    else begin
      r = r & ((64'sd1 <<< ow) - 1);
      if (r >= lim) r -= 2 * lim;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input v64 obs, input v64 exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv0(input bit v, input int a, input int b, input bit l);
    f0.i_VALID = v;
    f0.i_A = a[7:0];
    f0.i_B = b[7:0];
    f0.i_LAST = l;
  endtask
  // One cycle on d0 checked against the queue model: counts accepted pairs,
  // pops an expected result on every output transfer, checks stall behaviour.
  task automatic cyc0(input bit v, input int a, input int b, input bit l, input bit rdy, output bit acc);
    drv0(v, a, b, l);
    f0.i_READY = rdy;
    @(negedge clk);
    acc = v && f0.o_READY;
    chk("ready", f0.o_READY, !(f0.o_VALID && !rdy));
    if (was_stall) begin
      chk("hold_valid", f0.o_VALID, 1);
      chk("hold_res", f0.o_RESULT, prev_res);
    end
    if (f0.o_VALID && rdy) begin
      if (q.size() == 0) chk("extra_result", 1, 0);
      else chk("stream_res", f0.o_RESULT, q.pop_front());
    end
    if (acc) begin
      msum += a * b;
      if (l) begin
        q.push_back(model(msum, 4, 16));
        msum = 0;
      end
    end
    was_stall = f0.o_VALID && !rdy;
    prev_res = f0.o_RESULT;
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bit acc;
    int pa[5] = '{16, 32, 48, 5, 7};
    int pb[5] = '{1, 1, 1, 3, -9};
    bit pl[5] = '{1, 1, 1, 0, 1};
    int ta[3] = '{3, 5, 10};
    int tb[3] = '{4, -2, 10};
    int ba[3] = '{16, -9, -8};
    int be[3] = '{1, -1, 0};
    int sa[2] = '{127, -128};
    drv0(0, 0, 0, 0);
    f0.i_READY = 1;
    f1.i_VALID = 0; f1.i_A = 0; f1.i_B = 0; f1.i_LAST = 0; f1.i_READY = 1;
    f2.i_VALID = 0; f2.i_A = 0; f2.i_B = 0; f2.i_LAST = 0; f2.i_READY = 1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_valid", f0.o_VALID, 0);
    chk("rst_res", f0.o_RESULT, 0);
    chk("rst_ready", f0.o_READY, 1);
    chk("rst_valid1", f1.o_VALID, 0);
    rst = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      drv0(i < 3, i < 3 ? ta[i] : 0, i < 3 ? tb[i] : 0, i == 2);
      @(negedge clk);
      chk("t1_valid", f0.o_VALID, i == 4);
      if (i == 4) begin
        chk("t1_res", f0.o_RESULT, 6);
        chk("t1_model", f0.o_RESULT, model(3 * 4 + 5 * -2 + 10 * 10, 4, 16));
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      rst = i == 2;
      drv0(i < 4, i < 3 ? 100 : 2, i < 3 ? 100 : 3, i == 3);
      @(negedge clk);
      if (i >= 3) begin
        chk("rst_mid_valid", f0.o_VALID, i == 5);
        chk("rst_mid_res", f0.o_RESULT, i == 5 ? model(6, 4, 16) : 0);
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drv0(i < 3, i < 3 ? ba[i] : 0, 1, 1);
      @(negedge clk);
      chk("b2b_valid", f0.o_VALID, i >= 2 && i < 5);
      if (i >= 2 && i < 5) chk("b2b_res", f0.o_RESULT, be[i - 2]);
      step();
    end
    begin
      int idx = 0;
      for (int c = 0; c < 40 && (idx < 5 || q.size() > 0 || f0.o_VALID); c++) begin
        cyc0(idx < 5, pa[idx % 5], pb[idx % 5], pl[idx % 5], !(c >= 2 && c < 7), acc);
        if (acc) idx++;
      end
      chk("bp_sent", idx, 5);
      chk("bp_drain", q.size(), 0);
    end
    for (int c = 0; c < 400; c++)
      cyc0($urandom_range(0, 3) != 0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, acc);
    for (int c = 0; c < 10 && (q.size() > 0 || f0.o_VALID); c++) cyc0(0, 0, 0, 0, 1, acc);
    chk("rand_drain", q.size(), 0);
    drv0(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      f1.i_VALID = i < 2;
      f1.i_A = i < 2 ? sa[i][7:0] : 8'd0;
      f1.i_B = 8'sd127;
      f1.i_LAST = 1;
      @(negedge clk);
      if (i >= 2) begin
        chk("sat_valid", f1.o_VALID, 1);
        chk("sat_res", f1.o_RESULT, model(sa[i - 2] * 127, 0, 8));
        if (i == 2) chk("sat_res_const", f1.o_RESULT, SAT ? 127 : 1);
`ifdef FIXED_POINT_MACC_STREAM_SAT_EN
        chk("sat_flag", f1.o_SAT, 1);
`endif
      end
      step();
    end
    f1.i_VALID = 0;
    for (int i = 0; i < 258; i++) begin
      f2.i_VALID = i < 256;
      f2.i_A = -8'sd128;
      f2.i_B = -8'sd128;
      f2.i_LAST = i == 255;
      @(negedge clk);
      if (i == 256) chk("guard_early", f2.o_VALID, 0);
      if (i == 257) begin
        chk("guard_valid", f2.o_VALID, 1);
        chk("guard_res", f2.o_RESULT, 4194304);
        chk("guard_model", f2.o_RESULT, model(256 * 16384, 0, 24));
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
